// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: RV32M/RV64M funct3
// values and small decode helpers used by the unit and its integration.
package muldiv_pkg;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  // MULHSU treats rs1 as signed but rs2 as unsigned, hence the split helpers.
  function automatic logic srcaSigned(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic srcbSigned(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic isDivide(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic isRemainder(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit beside the EX-stage ALU: shift-add multiply and
// restoring divide on operand magnitudes, one bit per cycle, sign fixed at the end.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] srca,
  input  logic [XLEN-1:0] srcb,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} stateT;

  stateT               state;
  stateT               nextState;
  logic [2:0]          opReg;
  logic                negRes;
  logic                negRem;
  logic [XLEN-1:0]     magA;
  logic [XLEN-1:0]     magB;
  logic [2*XLEN-1:0]   prodReg;
  logic [XLEN:0]       remReg;
  logic [XLEN-1:0]     quoReg;
  logic [CW-1:0]       cnt;
  logic [XLEN-1:0]     resultReg;

  function automatic logic [XLEN-1:0] negateIf(input logic [XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  // Request decode: signs, magnitudes and the divide cases that skip CALC.
  logic            sgnA;
  logic            sgnB;
  logic [XLEN-1:0] absA;
  logic [XLEN-1:0] absB;
  logic            divByZero;
  logic            divOverflow;
  logic [XLEN-1:0] specialResult;

  always_comb begin
    sgnA          = srcaSigned(op) & srca[XLEN-1];
    sgnB          = srcbSigned(op) & srcb[XLEN-1];
    absA          = negateIf(srca, sgnA);
    absB          = negateIf(srcb, sgnB);
    divByZero     = isDivide(op) && (srcb == '0);
    divOverflow   = isDivide(op) && !op[0] && (srca == MIN_INT) && (srcb == '1);
    specialResult = '0;
    if (divByZero) begin
      specialResult = isRemainder(op) ? srca : '1;
    end else if (divOverflow) begin
      specialResult = isRemainder(op) ? '0 : MIN_INT;
    end
  end

  // One iteration of each algorithm, plus the sign-corrected value of the last one.
  logic [XLEN:0]     mulSum;
  logic [2*XLEN-1:0] prodNext;
  logic [2*XLEN-1:0] prodSigned;
  logic [XLEN+1:0]   divShift;
  logic [XLEN:0]     divDiff;
  logic              divFits;
  logic [XLEN:0]     remNext;
  logic [XLEN-1:0]   quoNext;
  logic [XLEN-1:0]   calcResult;
  logic              lastIter;

  always_comb begin
    mulSum     = {1'b0, prodReg[2*XLEN-1:XLEN]} + (prodReg[0] ? {1'b0, magA} : '0);
    prodNext   = {mulSum, prodReg[XLEN-1:1]};
    prodSigned = negRes ? -prodNext : prodNext;
    divShift   = {remReg, quoReg[XLEN-1]};
    divFits    = divShift >= {2'b00, magB};
    divDiff    = divShift[XLEN:0] - {1'b0, magB};
    remNext    = divFits ? divDiff : divShift[XLEN:0];
    quoNext    = {quoReg[XLEN-2:0], divFits};
    lastIter   = (cnt == CW'(XLEN - 1));
    calcResult = '0;
    if (isRemainder(opReg)) begin
      calcResult = negateIf(remNext[XLEN-1:0], negRem);
    end else if (isDivide(opReg)) begin
      calcResult = negateIf(quoNext, negRes);
    end else if (opReg == MD_MUL) begin
      calcResult = prodSigned[XLEN-1:0];
    end else begin
      calcResult = prodSigned[2*XLEN-1:XLEN];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // A flush always wins: it blocks a start in IDLE and abandons CALC.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (start && !flush) nextState = (divByZero || divOverflow) ? DONE : CALC;
      end
      CALC: begin
        if (flush)         nextState = IDLE;
        else if (lastIter) nextState = DONE;
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Datapath; result only changes on entry to DONE, so a flush leaves it intact.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opReg     <= '0;
      negRes    <= 1'b0;
      negRem    <= 1'b0;
      magA      <= '0;
      magB      <= '0;
      prodReg   <= '0;
      remReg    <= '0;
      quoReg    <= '0;
      cnt       <= '0;
      resultReg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !flush) begin
            opReg   <= op;
            negRes  <= sgnA ^ sgnB;
            negRem  <= sgnA;
            magA    <= absA;
            magB    <= absB;
            prodReg <= {{XLEN{1'b0}}, absB};
            remReg  <= '0;
            quoReg  <= absA;
            cnt     <= '0;
            if (divByZero || divOverflow) resultReg <= specialResult;
          end
        end
        CALC: begin
          if (!flush) begin
            cnt <= cnt + CW'(1);
            if (isDivide(opReg)) begin
              remReg <= remNext;
              quoReg <= quoNext;
            end else begin
              prodReg <= prodNext;
            end
            if (lastIter) resultReg <= calcResult;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy   = (state == CALC);
  assign done   = (state == DONE);
  assign result = resultReg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at XLEN=32 and XLEN=64: results, cycle timing,
// special divide cases, flush and asynchronous reset.
module tb_muldiv_unit;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [2:0]  op;
  logic        start32, start64;
  logic [31:0] srcA32, srcB32, result32;
  logic [63:0] srcA64, srcB64, result64;
  logic        busy32, done32, busy64, done64;

  int testCount = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .op(op), .srca(srcA32), .srcb(srcB32),
    .flush(flush), .busy(busy32), .done(done32), .result(result32)
  );

  muldiv_unit #(.XLEN(64)) dut64 (
    .clk(clk), .reset(reset), .start(start64), .op(op), .srca(srcA64), .srcb(srcB64),
    .flush(flush), .busy(busy64), .done(done64), .result(result64)
  );

  // Runs one 32-bit op and reports cycle numbers relative to the start cycle (0).
  // Returns in the cycle after done, i.e. the earliest cycle a new start is accepted.
  task automatic runOp32(input logic [2:0] opIn, input logic [31:0] a, input logic [31:0] b,
                         output int busyCount, output int firstBusy, output int lastBusy,
                         output int doneCycle, output logic [31:0] res);
    busyCount = 0; firstBusy = -1; lastBusy = -1; doneCycle = -1; res = '0;
    @(negedge clk);
    op = opIn; srcA32 = a; srcB32 = b; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      if (busy32) begin
        busyCount++;
        if (firstBusy < 0) firstBusy = cyc;
        lastBusy = cyc;
      end
      if (done32) begin
        doneCycle = cyc;
        res = result32;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic runOp64(input logic [2:0] opIn, input logic [63:0] a, input logic [63:0] b,
                         output int busyCount, output int doneCycle, output logic [63:0] res);
    busyCount = 0; doneCycle = -1; res = '0;
    @(negedge clk);
    op = opIn; srcA64 = a; srcB64 = b; start64 = 1'b1;
    @(posedge clk); #1;
    start64 = 1'b0;
    for (int cyc = 1; cyc <= 150; cyc++) begin
      if (busy64) busyCount++;
      if (done64) begin
        doneCycle = cyc;
        res = result64;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; flush = 1'b0; start32 = 1'b0; start64 = 1'b0; op = OP_MUL;
    srcA32 = '0; srcB32 = '0; srcA64 = '0; srcB64 = '0;
    repeat (2) @(posedge clk);
    #1;
    testCount++;
    if ({busy32, done32, result32} !== 34'h0) begin
      failCount++;
      $display("[TB] FAIL reset32: busy=%b done=%b result=%h expected 0/0/0", busy32, done32, result32);
    end
    testCount++;
    if ({busy64, done64, result64} !== 66'h0) begin
      failCount++;
      $display("[TB] FAIL reset64: busy=%b done=%b result=%h expected 0/0/0", busy64, done64, result64);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_mul;
    logic [2:0]  ops  [4] = '{OP_MUL, OP_MULH, OP_MULHU, OP_MULHSU};
    logic [31:0] as   [4] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] bs   [4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2};
    logic [31:0] exps [4] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    int busyCount, firstBusy, lastBusy, doneCycle;
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      runOp32(ops[i], as[i], bs[i], busyCount, firstBusy, lastBusy, doneCycle, res);
      testCount++;
      if (res !== exps[i]) begin
        failCount++;
        $display("[TB] FAIL mul[%0d] result: got %h expected %h", i, res, exps[i]);
      end
      testCount++;
      if (doneCycle !== 33) begin
        failCount++;
        $display("[TB] FAIL mul[%0d] doneCycle: got %0d expected 33", i, doneCycle);
      end
      if (i == 0) begin
        testCount++;
        if (firstBusy !== 1 || lastBusy !== 32 || busyCount !== 32) begin
          failCount++;
          $display("[TB] FAIL mul busy window: got %0d..%0d (%0d cycles) expected 1..32 (32)",
                   firstBusy, lastBusy, busyCount);
        end
      end
    end
  endtask

  // Consecutive ops each start in the first cycle the unit is back in IDLE.
  task automatic test_back_to_back_div;
    logic [2:0]  ops  [4] = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU};
    logic [31:0] as   [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
    logic [31:0] bs   [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] exps [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
    int busyCount, firstBusy, lastBusy, doneCycle;
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      runOp32(ops[i], as[i], bs[i], busyCount, firstBusy, lastBusy, doneCycle, res);
      testCount++;
      if (res !== exps[i]) begin
        failCount++;
        $display("[TB] FAIL div[%0d] result: got %h expected %h", i, res, exps[i]);
      end
      testCount++;
      if (doneCycle !== 33 || busyCount !== 32) begin
        failCount++;
        $display("[TB] FAIL div[%0d] timing: done=%0d busy=%0d expected 33/32", i, doneCycle, busyCount);
      end
    end
  endtask

  task automatic test_special_div;
    logic [2:0]  ops  [4] = '{OP_DIVU, OP_REM, OP_REM, OP_DIV};
    logic [31:0] as   [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs   [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exps [4] = '{32'hFFFF_FFFF, 32'd5, 32'd0, 32'h8000_0000};
    int busyCount, firstBusy, lastBusy, doneCycle;
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      runOp32(ops[i], as[i], bs[i], busyCount, firstBusy, lastBusy, doneCycle, res);
      testCount++;
      if (res !== exps[i]) begin
        failCount++;
        $display("[TB] FAIL special[%0d] result: got %h expected %h", i, res, exps[i]);
      end
      testCount++;
      if (doneCycle !== 1 || busyCount !== 0) begin
        failCount++;
        $display("[TB] FAIL special[%0d] timing: done=%0d busy=%0d expected 1/0", i, doneCycle, busyCount);
      end
    end
  endtask

  task automatic test_flush;
    int busyCount, firstBusy, lastBusy, doneCycle;
    logic [31:0] res;
    @(negedge clk);
    op = OP_DIVU; srcA32 = 32'd100; srcB32 = 32'd7; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    testCount++;
    if (busy32 !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL flush busy in cycle 10: got %b expected 1", busy32);
    end
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    testCount++;
    if (busy32 !== 1'b0 || done32 !== 1'b0 || result32 !== 32'h8000_0000) begin
      failCount++;
      $display("[TB] FAIL flush cycle 11: busy=%b done=%b result=%h expected 0/0/80000000",
               busy32, done32, result32);
    end
    runOp32(OP_MUL, 32'h0001_2345, 32'h10, busyCount, firstBusy, lastBusy, doneCycle, res);
    testCount++;
    if (doneCycle !== 33 || res !== 32'h0012_3450) begin
      failCount++;
      $display("[TB] FAIL mul after flush: done=%0d result=%h expected 33/00123450", doneCycle, res);
    end
    @(negedge clk);
    op = OP_MUL; srcA32 = 32'd3; srcB32 = 32'd3; start32 = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0; flush = 1'b0;
    @(posedge clk); #1;
    testCount++;
    if (busy32 !== 1'b0 || done32 !== 1'b0 || result32 !== 32'h0012_3450) begin
      failCount++;
      $display("[TB] FAIL flush beats start: busy=%b done=%b result=%h expected 0/0/00123450",
               busy32, done32, result32);
    end
  endtask

  task automatic test_reset_mid;
    int busyCount, firstBusy, lastBusy, doneCycle;
    logic [31:0] res;
    @(negedge clk);
    op = OP_MUL; srcA32 = 32'd7; srcB32 = 32'd3; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    testCount++;
    if (busy32 !== 1'b0 || done32 !== 1'b0 || result32 !== 32'h0) begin
      failCount++;
      $display("[TB] FAIL async reset32: busy=%b done=%b result=%h expected 0/0/0", busy32, done32, result32);
    end
    #1;
    reset = 1'b0;
    runOp32(OP_MUL, 32'd7, 32'd3, busyCount, firstBusy, lastBusy, doneCycle, res);
    testCount++;
    if (doneCycle !== 33 || res !== 32'd21) begin
      failCount++;
      $display("[TB] FAIL mul after reset: done=%0d result=%h expected 33/00000015", doneCycle, res);
    end
  endtask

  task automatic test_xlen64;
    int busyCount, doneCycle;
    logic [63:0] res;
    runOp64(OP_MUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, busyCount, doneCycle, res);
    testCount++;
    if (doneCycle !== 65 || busyCount !== 64 || res !== 64'hFFFF_FFFF_FFFF_FFEB) begin
      failCount++;
      $display("[TB] FAIL mul64: done=%0d busy=%0d result=%h expected 65/64/ffffffffffffffeb",
               doneCycle, busyCount, res);
    end
    runOp64(OP_MULHU, '1, '1, busyCount, doneCycle, res);
    testCount++;
    if (res !== 64'hFFFF_FFFF_FFFF_FFFE) begin
      failCount++;
      $display("[TB] FAIL mulhu64: got %h expected fffffffffffffffe", res);
    end
    @(negedge clk);
    op = OP_MUL; srcA64 = 64'd9; srcB64 = 64'd9; start64 = 1'b1;
    @(posedge clk); #1;
    start64 = 1'b0;
    repeat (20) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    testCount++;
    if (busy64 !== 1'b0 || done64 !== 1'b0 || result64 !== 64'h0) begin
      failCount++;
      $display("[TB] FAIL async reset64: busy=%b done=%b result=%h expected 0/0/0", busy64, done64, result64);
    end
    #1;
    reset = 1'b0;
    runOp64(OP_MUL, 64'd9, 64'd9, busyCount, doneCycle, res);
    testCount++;
    if (doneCycle !== 65 || res !== 64'd81) begin
      failCount++;
      $display("[TB] FAIL mul64 after reset: done=%0d result=%h expected 65/0000000000000051", doneCycle, res);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_back_to_back_div();
    test_special_div();
    test_flush();
    test_reset_mid();
    test_xlen64();
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
